// File: rtl/ahb_dma_sched_pkg.sv
// Shared types and helpers for the DMA channel time-slicing scheduler.
package ahb_dma_sched_pkg;

    localparam int unsigned PRI_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        GRANT,
        RUN,
        YIELD
    } sched_state_t;

    // Next channel index, wrapping from ch_num-1 back to 0.
    function automatic int unsigned ch_wrap_inc(input int unsigned idx, input int unsigned ch_num);
        return (idx + 32'd1 >= ch_num) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/ahb_dma_pri_rr_pick.sv
// Combinational picker: highest priority requester wins, ties resolved
// round-robin starting just after last_ch.
module ahb_dma_pri_rr_pick #(
    parameter int unsigned CH_NUM  = 15,
    parameter int unsigned CH_BITS = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int unsigned PRI_W   = ahb_dma_sched_pkg::PRI_W
) (
    input  logic [CH_NUM-1:0]       req,
    input  logic [CH_NUM*PRI_W-1:0] pri,
    input  logic [CH_BITS-1:0]      last_ch,
    output logic [CH_BITS-1:0]      winner,
    output logic                    any_req
);
    import ahb_dma_sched_pkg::*;

    logic [PRI_W-1:0]   w_pri [CH_NUM];
    logic [CH_BITS-1:0] w_start;
    logic [CH_BITS:0]   w_pos;
    logic [CH_BITS-1:0] w_idx;
    logic [CH_BITS-1:0] w_win;
    logic [PRI_W-1:0]   w_best_pri;
    logic               w_found;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_unpack
        assign w_pri[g] = pri[g*PRI_W +: PRI_W];
    end

    assign w_start = CH_BITS'(ch_wrap_inc(32'(last_ch), CH_NUM));

    // Scan in round-robin order; a strictly greater priority is needed to
    // displace an earlier candidate, so equal priorities keep RR order.
    always_comb begin
        w_pos      = '0;
        w_idx      = '0;
        w_win      = '0;
        w_best_pri = '0;
        w_found    = 1'b0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            w_pos = {1'b0, w_start} + (CH_BITS+1)'(k);
            if (w_pos >= (CH_BITS+1)'(CH_NUM)) begin
                w_pos = w_pos - (CH_BITS+1)'(CH_NUM);
            end
            w_idx = w_pos[CH_BITS-1:0];
            if (req[w_idx] && (!w_found || (w_pri[w_idx] > w_best_pri))) begin
                w_win      = w_idx;
                w_best_pri = w_pri[w_idx];
                w_found    = 1'b1;
            end
        end
    end

    assign winner  = w_win;
    assign any_req = |req;

endmodule

// File: rtl/ahb_dma_ch_sched.sv
// Time-slicing scheduler sharing one DMA transfer engine among all channels:
// arbitrates, grants, counts beats against a quota and requests yields.
module ahb_dma_ch_sched #(
    parameter int unsigned CH_NUM  = 15,
    parameter int unsigned CH_BITS = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int unsigned PRI_W   = ahb_dma_sched_pkg::PRI_W,
    parameter int unsigned QUOTA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_NUM-1:0]       req,
    input  logic [CH_NUM*PRI_W-1:0] pri,
    input  logic [QUOTA_W-1:0]      quota,
    input  logic                    eng_start,
    input  logic                    beat_done,
    input  logic                    ch_done,
    input  logic                    yield_ack,
    output logic                    gnt_valid,
    output logic [CH_BITS-1:0]      gnt_ch,
    output logic                    busy,
    output logic                    yield,
    output logic                    done_vld,
    output logic [CH_BITS-1:0]      done_ch
);
    import ahb_dma_sched_pkg::*;

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;

    logic [CH_BITS-1:0] r_sel_ch,    w_sel_ch_nxt;
    logic [CH_BITS-1:0] r_last_ch,   w_last_ch_nxt;
    logic [QUOTA_W-1:0] r_beat_cnt,  w_beat_cnt_nxt;
    logic               r_gnt_valid, w_gnt_valid_nxt;
    logic [CH_BITS-1:0] r_gnt_ch,    w_gnt_ch_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_yield,     w_yield_nxt;
    logic               r_done_vld,  w_done_vld_nxt;
    logic [CH_BITS-1:0] r_done_ch,   w_done_ch_nxt;

    logic [CH_BITS-1:0] w_winner;
    logic               w_any_req;
    logic [CH_NUM-1:0]  w_other_req;
    logic [PRI_W-1:0]   w_pri [CH_NUM];
    logic [PRI_W-1:0]   w_pri_sel;
    logic [CH_NUM-1:0]  w_hi_vec;
    logic               w_hi_pri;
    logic               w_exhausted;
    logic [QUOTA_W-1:0] w_cnt_base;

    ahb_dma_pri_rr_pick #(
        .CH_NUM  (CH_NUM),
        .CH_BITS (CH_BITS),
        .PRI_W   (PRI_W)
    ) u_pick (
        .req     (req),
        .pri     (pri),
        .last_ch (r_last_ch),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    // Requesters other than the running channel, and which of them outrank it.
    assign w_other_req = req & ~(CH_NUM'(1) << r_sel_ch);
    assign w_pri_sel   = w_pri[r_sel_ch];

    for (genvar g = 0; g < CH_NUM; g++) begin : g_pri
        assign w_pri[g]    = pri[g*PRI_W +: PRI_W];
        assign w_hi_vec[g] = w_other_req[g] && (w_pri[g] > w_pri_sel);
    end

    assign w_hi_pri    = |w_hi_vec;
    assign w_exhausted = (quota != '0) && (r_beat_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_ch_nxt    = r_sel_ch;
        w_last_ch_nxt   = r_last_ch;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_ch_nxt    = r_gnt_ch;
        w_busy_nxt      = r_busy;
        w_yield_nxt     = r_yield;
        w_done_vld_nxt  = 1'b0;
        w_done_ch_nxt   = r_done_ch;
        w_cnt_base      = r_beat_cnt;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ARB;
                end
            end

            ARB: begin
                if (w_any_req) begin
                    w_sel_ch_nxt    = w_winner;
                    w_gnt_ch_nxt    = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_state_nxt     = GRANT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            GRANT: begin
                if (eng_start) begin
                    w_beat_cnt_nxt  = quota;
                    w_busy_nxt      = 1'b1;
                    w_gnt_valid_nxt = 1'b0;
                    w_state_nxt     = RUN;
                end
            end

            RUN: begin
                if (ch_done) begin
                    w_done_vld_nxt = 1'b1;
                    w_done_ch_nxt  = r_sel_ch;
                    w_last_ch_nxt  = r_sel_ch;
                    w_busy_nxt     = 1'b0;
                    w_yield_nxt    = 1'b0;
                    w_state_nxt    = w_any_req ? ARB : IDLE;
                end else if (yield_ack) begin
                    w_last_ch_nxt = r_sel_ch;
                    w_busy_nxt    = 1'b0;
                    w_yield_nxt   = 1'b0;
                    w_state_nxt   = YIELD;
                end else begin
                    // Spent slice: yield if someone else waits, otherwise start a fresh slice.
                    if (w_exhausted) begin
                        if (|w_other_req) begin
                            w_yield_nxt = 1'b1;
                        end else begin
                            w_cnt_base = quota;
                        end
                    end
                    if (beat_done && (quota != '0) && (w_cnt_base != '0)) begin
                        w_cnt_base = w_cnt_base - QUOTA_W'(1);
                    end
                    w_beat_cnt_nxt = w_cnt_base;
                    if (beat_done && w_hi_pri) begin
                        w_yield_nxt = 1'b1;
                    end
                end
            end

            YIELD: begin
                w_state_nxt = ARB;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_ch    <= '0;
            r_last_ch   <= CH_BITS'(CH_NUM - 1);
            r_beat_cnt  <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_ch    <= '0;
            r_busy      <= 1'b0;
            r_yield     <= 1'b0;
            r_done_vld  <= 1'b0;
            r_done_ch   <= '0;
        end else begin
            r_sel_ch    <= w_sel_ch_nxt;
            r_last_ch   <= w_last_ch_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt_ch    <= w_gnt_ch_nxt;
            r_busy      <= w_busy_nxt;
            r_yield     <= w_yield_nxt;
            r_done_vld  <= w_done_vld_nxt;
            r_done_ch   <= w_done_ch_nxt;
        end
    end

    assign gnt_valid = r_gnt_valid;
    assign gnt_ch    = r_gnt_ch;
    assign busy      = r_busy;
    assign yield     = r_yield;
    assign done_vld  = r_done_vld;
    assign done_ch   = r_done_ch;

endmodule
